pitch_detect: RTL and testbench



---
 rtl/pitch_detect.sv | 114 +++++++++++
 tb/tb_pitch_detect.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pitch_detect.sv
// Rising-zero-crossing pitch detector: hysteresis FSM, averaged period over a
// window of 2^AVG_LOG2 periods, nearest-note lookup and no-signal timeout.
module pitch_detect #(
  parameter logic [23:0] HYST       = 24'd4096,
  parameter int          AVG_LOG2   = 2,
  parameter int          MIN_PERIOD = 20,
  parameter int          MAX_PERIOD = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [23:0] sample_in,
  output logic [15:0] period,
  output logic [2:0]  note,
  output logic        valid,
  output logic        no_signal
);

  localparam logic [0:0] ST_ARM  = 1'b0;
  localparam logic [0:0] ST_TRIG = 1'b1;

  localparam logic signed [24:0] POS_TH = $signed({1'b0, HYST});
  localparam logic signed [24:0] NEG_TH = -$signed({1'b0, HYST});
  localparam logic [15:0] CNT_MAX = 16'(MAX_PERIOD);
  localparam logic [15:0] P_MIN   = 16'(MIN_PERIOD);
  localparam logic [AVG_LOG2:0] K_LAST = {(AVG_LOG2+1){1'b1}} >> 1;

  logic [0:0]        state;
  logic [15:0]       cnt;
  logic [17:0]       acc;
  logic [AVG_LOG2:0] k;
  logic              have_ref;

  logic signed [24:0] samp;
  logic               arm_hit;
  logic               trig_hit;
  logic               crossing;
  logic [15:0]        p;
  logic [17:0]        acc_sum;
  logic [17:0]        avg;

  assign samp     = $signed({sample_in[23], sample_in});
  assign arm_hit  = samp < NEG_TH;
  assign trig_hit = samp >= POS_TH;
  assign crossing = (state == ST_TRIG) && trig_hit;
  assign p        = cnt + 16'd1;
  assign acc_sum  = acc + {2'b00, p};
  assign avg      = acc_sum >> AVG_LOG2;

  // Thresholds sit halfway between adjacent note periods at 48 kHz.
  function automatic logic [2:0] note_of(input logic [17:0] a);
    if      (a >= 18'd173) note_of = 3'd0;
    else if (a >= 18'd154) note_of = 3'd1;
    else if (a >= 18'd141) note_of = 3'd2;
    else if (a >= 18'd130) note_of = 3'd3;
    else if (a >= 18'd116) note_of = 3'd4;
    else if (a >= 18'd103) note_of = 3'd5;
    else if (a >= 18'd94)  note_of = 3'd6;
    else                   note_of = 3'd7;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ARM;
      cnt       <= '0;
      acc       <= '0;
      k         <= '0;
      have_ref  <= 1'b0;
      period    <= '0;
      note      <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      valid <= 1'b0;
      if (sample_en) begin
        if (crossing) begin
          state <= ST_ARM;
          cnt   <= '0;
          if (!have_ref) begin
            have_ref <= 1'b1;
          end else if (p < P_MIN) begin
            acc <= '0;
            k   <= '0;
          end else if (k == K_LAST) begin
            period    <= avg[15:0];
            note      <= note_of(avg);
            valid     <= 1'b1;
            no_signal <= 1'b0;
            acc       <= '0;
            k         <= '0;
          end else begin
            acc <= acc_sum;
            k   <= k + 1'b1;
          end
        end else begin
          if (state == ST_ARM && arm_hit) state <= ST_TRIG;
          // Timeout fires only on the step into saturation so a silent input
          // does not keep forcing the FSM back to ARM on every sample.
          if (cnt != CNT_MAX) begin
            cnt <= p;
            if (p == CNT_MAX) begin
              no_signal <= 1'b1;
              have_ref  <= 1'b0;
              acc       <= '0;
              k         <= '0;
              state     <= ST_ARM;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pitch_detect.sv
// Directed-vector scoreboard bench for pitch_detect.
module tb_pitch_detect;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic [23:0] sample_in = '0;
  logic [15:0] period;
  logic [2:0]  note;
  logic        valid;
  logic        no_signal;

  localparam int AMP = 24'h100000;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  pitch_detect dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .sample_in(sample_in),
    .period(period), .note(note), .valid(valid), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got period %0d note %0d, none expected", period, note);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("valid_period", int'(period), int'(e[18:3]));
        chk("valid_note", int'(note), int'(e[2:0]));
        chk("valid_no_signal", int'(no_signal), 0);
      end
    end
  end

  task automatic expect_out(input int per, input int nt);
    exp_q.push_back({16'(per), 3'(nt)});
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic send_sample(input int v);
    @(negedge clk); sample_en = 1'b1; sample_in = 24'(v);
    @(negedge clk); sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One period: first half positive, second half negative; the crossing
  // fires on the first positive sample of the following period.
  task automatic play(input int plen, input int pos, input int neg);
    for (int i = 0; i < plen; i++) send_sample((i < plen / 2) ? pos : neg);
  endtask

  task automatic play_n(input int n, input int plen);
    for (int i = 0; i < n; i++) play(plen, AMP, -AMP);
  endtask

  task automatic play_const(input int n, input int v);
    for (int i = 0; i < n; i++) send_sample(v);
  endtask

  int sweep_p[7]  = '{183, 173, 172, 94, 93, 92, 20};
  int sweep_nt[7] = '{0, 0, 1, 6, 7, 7, 7};
  int trunc_l[6]  = '{110, 110, 110, 111, 112, 110};
  int glitch_l[9] = '{110, 110, 110, 10, 110, 110, 110, 110, 110};

  initial begin
    do_reset();
    chk("rst_period", int'(period), 0);
    chk("rst_note", int'(note), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_no_signal", int'(no_signal), 1);

    // Steady tone: 9 crossings -> reference + 8 periods -> two windows.
    expect_out(110, 5);
    expect_out(110, 5);
    play_n(10, 110);
    chk("tone_no_signal", int'(no_signal), 0);

    // Silence: cnt is 109 after the last period, reaches 1023 after 914 samples.
    play_const(913, 0);
    chk("pre_timeout_no_signal", int'(no_signal), 0);
    play_const(1, 0);
    chk("timeout_no_signal", int'(no_signal), 1);
    chk("timeout_period_hold", int'(period), 110);
    chk("timeout_note_hold", int'(note), 5);
    play_const(200, 0);
    chk("silence_no_signal", int'(no_signal), 1);

    // Recovery after timeout needs a fresh reference plus four periods.
    expect_out(110, 5);
    play_n(6, 110);
    chk("recover_no_signal", int'(no_signal), 0);

    foreach (sweep_p[i]) begin
      do_reset();
      expect_out(sweep_p[i], sweep_nt[i]);
      play_n(6, sweep_p[i]);
    end

    // Period 19 is below the minimum: every window is discarded.
    do_reset();
    play_n(6, 19);
    chk("short_no_signal", int'(no_signal), 1);

    // Average of 110,110,111,112 = 443/4 truncates to 110.
    do_reset();
    expect_out(110, 5);
    foreach (trunc_l[i]) play(trunc_l[i], AMP, -AMP);

    // Exactly -HYST never arms.
    do_reset();
    play(110, 4096, -4096);
    play(110, 4096, -4096);
    play(110, 4096, -4096);
    play(110, 4096, -4096);
    play(110, 4096, -4096);
    play(110, 4096, -4096);
    chk("hyst_edge_no_signal", int'(no_signal), 1);
    // Just below -HYST arms; exactly +HYST triggers.
    do_reset();
    expect_out(110, 5);
    for (int i = 0; i < 6; i++) play(110, 4096, -4097);

    // Noise inside the hysteresis band.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      send_sample(2000);
      send_sample(-2000);
    end
    chk("noise_no_signal", int'(no_signal), 1);

    // Short glitch period after two accepted periods discards the window.
    do_reset();
    expect_out(110, 5);
    foreach (glitch_l[i]) play(glitch_l[i], AMP, -AMP);

    // Reset coincident with sample_en mid-window.
    do_reset();
    expect_out(110, 5);
    play_n(6, 110);
    play_n(3, 110);
    @(negedge clk); reset = 1'b1; sample_en = 1'b1; sample_in = 24'(AMP);
    @(negedge clk); reset = 1'b0; sample_en = 1'b0;
    chk("midrst_period", int'(period), 0);
    chk("midrst_note", int'(note), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_no_signal", int'(no_signal), 1);
    play_n(5, 130);
    chk("midrst_4cross_no_signal", int'(no_signal), 1);
    expect_out(130, 3);
    play_n(1, 130);

    repeat (10) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
